alu_core: RTL and testbench
===========================

// Module: alu_core
// PURPOSE
//   32-bit integer ALU for the five-stage pipelined processor's execute stage.
//   Computes add, sub, and, or, sll and sra on two operands, plus compare flags for branches.
//   Outputs are registered, giving one cycle of latency into the X/M boundary.
// PARAMETERS
//   none (datapath fixed at 32 bits, shift amount 5 bits, opcode 5 bits)
// PORTS
//   clock           in   1   single clock; all state updates on the rising edge
//   reset           in   1   synchronous, active-high; clears all output registers
//   data_operandA   in   32  operand A (two's complement)
//   data_operandB   in   32  operand B (two's complement)
//   ctrl_ALUopcode  in   5   operation select
//   ctrl_shiftamt   in   5   shift distance for SLL/SRA (0..31)
//   data_result     out  32  registered result
//   isNotEqual      out  1   registered: A != B
//   isLessThan      out  1   registered: A < B, signed
//   overflow        out  1   registered: signed overflow of ADD/SUB
// BEHAVIOUR
//   - Reset: when reset=1 at a rising edge, all four outputs become 0. Reset takes priority over new inputs.
//   - Latency: inputs are sampled at edge N; the outputs for that operation are valid after edge N and hold until edge N+1.
//     There is no handshake; a new operation can be issued every cycle.
//   - Opcodes:
//     - 00000 ADD: A+B, modulo 2^32.
//     - 00001 SUB: A-B, computed as A + ~B + 1.
//     - 00010 AND: A&B.
//     - 00011 OR: A|B.
//     - 00100 SLL: A << shiftamt, zero-fill.
//     - 00101 SRA: A >>> shiftamt, sign-fill.
//   - Any other opcode: data_result=0 and overflow=0 (except the ALU_EXT_OPS_EN codes below).
//   - Adder: a single 32-bit carry-lookahead adder (8-bit blocks) is shared by ADD and SUB.
//   - overflow:
//     - ADD: set iff A[31]==B[31] and sum[31]!=A[31].
//     - SUB: set iff A[31]!=B[31] and diff[31]!=A[31].
//     - All other opcodes: 0.
//   - Compare flags are always computed from the A-B subtractor path, independent of the opcode:
//     - isNotEqual = |(A-B).
//     - isLessThan = diff[31] XOR sub_overflow.
//     - Boundary: A=0x80000000, B=1 gives isLessThan=1 even though diff[31]=0.
//   - Shifter: log-barrel with 5 stages (16/8/4/2/1). shiftamt=0 passes A unchanged. B is ignored for shifts.
//   - Shift edge: SRA of a negative number by 31 gives 0xFFFFFFFF.
//   - No internal state other than the output registers; all flags are 0 after reset until the first sampled operation.
// CONFIGURATION
//   ALU_EXT_OPS_EN defined:
//     - Adds 00110 XOR (A^B) and 00111 SRL (A >> shiftamt, zero-fill).
//     - overflow=0 for both.
//   ALU_EXT_OPS_EN undefined:
//     - 00110 and 00111 behave as unused opcodes (result 0).
//     - No XOR or SRL logic is synthesized.
// TESTING
//   - AND: A=3, B=1, op=00010, shamt=0 -> result 0x00000001, isNotEqual=1, isLessThan=0, overflow=0.
//   - ADD overflow: A=0x7FFFFFFF, B=1, op=00000 -> result 0x80000000, overflow=1.
//     Compare flags for the same inputs: isLessThan=0, isNotEqual=1.
//   - SUB / compare: A=0x80000000, B=1, op=00001 -> result 0x7FFFFFFF, overflow=1, isLessThan=1, isNotEqual=1.
//   - Shifts with A=0x80000010, shamt=4:
//     - SLL -> 0x00000100.
//     - SRA -> 0xF8000001.
//     - shamt=0 -> A unchanged.
//   - Equal operands: A=B=0x12345678, op=00011 -> result 0x12345678, isNotEqual=0, isLessThan=0.
//   - Reset / latency:
//     - Drive ADD 5+7, assert reset on the same edge -> all outputs 0.
//     - Deassert reset -> result 12 appears one edge after sampling.

Source files
------------

// File: rtl/alu_core.sv
// alu_core: 32-bit execute-stage ALU with registered outputs (one cycle latency).
// Operations: ADD, SUB, AND, OR, SLL, SRA; compare flags come from a dedicated A-B path.
// Optional feature macro: ALU_EXT_OPS_EN adds XOR (00110) and SRL (00111).
// Without it those two codes behave like any other unused opcode (result 0).
// Interface: no handshake. Inputs are sampled on every rising edge, and the registered
// outputs hold until the next edge, so a new operation may be issued every cycle.
module alu_core (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic [4:0]  ctrl_ALUopcode,
  input  logic [4:0]  ctrl_shiftamt,
  output logic [31:0] data_result,
  output logic        isNotEqual,
  output logic        isLessThan,
  output logic        overflow
);

  localparam logic [4:0] OP_ADD = 5'b00000;
  localparam logic [4:0] OP_SUB = 5'b00001;
  localparam logic [4:0] OP_AND = 5'b00010;
  localparam logic [4:0] OP_OR  = 5'b00011;
  localparam logic [4:0] OP_SLL = 5'b00100;
  localparam logic [4:0] OP_SRA = 5'b00101;
`ifdef ALU_EXT_OPS_EN
  localparam logic [4:0] OP_XOR = 5'b00110;
  localparam logic [4:0] OP_SRL = 5'b00111;
`endif

  // Carry-lookahead adder built from four 8-bit blocks. Each block produces its own
  // group generate/propagate, and those signals drive the carry into the next block.
  function automatic logic [31:0] cla_add(input logic [31:0] a, input logic [31:0] b,
                                          input logic cin);
    logic [31:0] g;
    logic [31:0] p;
    logic [31:0] c;
    logic        bg;
    logic        bp;
    logic        carry;
    g     = a & b;
    p     = a ^ b;
    c     = '0;
    carry = cin;
    for (int k = 0; k < 4; k++) begin
      bg = 1'b0;
      bp = 1'b1;
      for (int i = 0; i < 8; i++) begin
        bg = g[8*k+i] | (p[8*k+i] & bg);
        bp = bp & p[8*k+i];
      end
      c[8*k] = carry;
      for (int i = 0; i < 7; i++) begin
        c[8*k+i+1] = g[8*k+i] | (p[8*k+i] & c[8*k+i]);
      end
      carry = bg | (bp & carry);
    end
    return p ^ c;
  endfunction

  logic        is_sub;
  logic [31:0] add_b;
  logic [31:0] add_sum;
  logic        add_ov;
  logic [31:0] cmp_diff;
  logic        cmp_ov;
  logic [31:0] sll_val;
  logic [31:0] sra_val;
`ifdef ALU_EXT_OPS_EN
  logic [31:0] srl_val;
`endif
  logic [31:0] result_d;
  logic        ne_d;
  logic        lt_d;
  logic        ov_d;
  logic [31:0] result_q;
  logic        ne_q;
  logic        lt_q;
  logic        ov_q;

  // Shared ADD/SUB adder: for SUB, B is inverted and the carry-in is set to 1.
  // The compare flags need A-B on every cycle, even when the opcode is ADD, so they use a separate subtractor.
  always_comb begin
    is_sub   = (ctrl_ALUopcode == OP_SUB);
    add_b    = is_sub ? ~data_operandB : data_operandB;
    add_sum  = cla_add(data_operandA, add_b, is_sub);
    // add_b already carries the inversion, so one rule covers both ADD and SUB.
    add_ov   = (data_operandA[31] == add_b[31]) && (add_sum[31] != data_operandA[31]);
    cmp_diff = cla_add(data_operandA, ~data_operandB, 1'b1);
    cmp_ov   = (data_operandA[31] != data_operandB[31]) && (cmp_diff[31] != data_operandA[31]);
  end

  // Five-stage log barrel shifters (16/8/4/2/1); B is not used here.
  always_comb begin
    sll_val = data_operandA;
    sra_val = data_operandA;
    if (ctrl_shiftamt[4]) sll_val = {sll_val[15:0], 16'b0};
    if (ctrl_shiftamt[3]) sll_val = {sll_val[23:0], 8'b0};
    if (ctrl_shiftamt[2]) sll_val = {sll_val[27:0], 4'b0};
    if (ctrl_shiftamt[1]) sll_val = {sll_val[29:0], 2'b0};
    if (ctrl_shiftamt[0]) sll_val = {sll_val[30:0], 1'b0};
    if (ctrl_shiftamt[4]) sra_val = {{16{sra_val[31]}}, sra_val[31:16]};
    if (ctrl_shiftamt[3]) sra_val = {{8{sra_val[31]}}, sra_val[31:8]};
    if (ctrl_shiftamt[2]) sra_val = {{4{sra_val[31]}}, sra_val[31:4]};
    if (ctrl_shiftamt[1]) sra_val = {{2{sra_val[31]}}, sra_val[31:2]};
    if (ctrl_shiftamt[0]) sra_val = {sra_val[31], sra_val[31:1]};
`ifdef ALU_EXT_OPS_EN
    srl_val = data_operandA;
    if (ctrl_shiftamt[4]) srl_val = {16'b0, srl_val[31:16]};
    if (ctrl_shiftamt[3]) srl_val = {8'b0, srl_val[31:8]};
    if (ctrl_shiftamt[2]) srl_val = {4'b0, srl_val[31:4]};
    if (ctrl_shiftamt[1]) srl_val = {2'b0, srl_val[31:2]};
    if (ctrl_shiftamt[0]) srl_val = {1'b0, srl_val[31:1]};
`endif
  end

  // Result and flag selection; opcodes with no defined operation return zero.
  always_comb begin
    result_d = '0;
    ov_d     = 1'b0;
    ne_d     = |cmp_diff;
    lt_d     = cmp_diff[31] ^ cmp_ov;
    case (ctrl_ALUopcode)
      OP_ADD: begin result_d = add_sum; ov_d = add_ov; end
      OP_SUB: begin result_d = add_sum; ov_d = add_ov; end
      OP_AND: result_d = data_operandA & data_operandB;
      OP_OR:  result_d = data_operandA | data_operandB;
      OP_SLL: result_d = sll_val;
      OP_SRA: result_d = sra_val;
`ifdef ALU_EXT_OPS_EN
      OP_XOR: result_d = data_operandA ^ data_operandB;
      OP_SRL: result_d = srl_val;
`endif
      default: result_d = '0;
    endcase
  end

  // Output registers; reset has priority over the operation sampled on the same edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      result_q <= '0;
      ne_q     <= 1'b0;
      lt_q     <= 1'b0;
      ov_q     <= 1'b0;
    end else begin
      result_q <= result_d;
      ne_q     <= ne_d;
      lt_q     <= lt_d;
      ov_q     <= ov_d;
    end
  end

  assign data_result = result_q;
  assign isNotEqual  = ne_q;
  assign isLessThan  = lt_q;
  assign overflow    = ov_q;

endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core: directed and randomized checks of alu_core against a behavioural model.
// Honours ALU_EXT_OPS_EN the same way as the design.
module tb_alu_core;

  logic        clock;
  logic        reset;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [4:0]  ctrl_ALUopcode;
  logic [4:0]  ctrl_shiftamt;
  logic [31:0] data_result;
  logic        isNotEqual;
  logic        isLessThan;
  logic        overflow;

  int tests_run;
  int tests_failed;

  // Expected entry packing: {result[31:0], isNotEqual, isLessThan, overflow}
  logic [34:0] exp_q[$];

  alu_core dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_ALUopcode (ctrl_ALUopcode),
    .ctrl_shiftamt  (ctrl_shiftamt),
    .data_result    (data_result),
    .isNotEqual     (isNotEqual),
    .isLessThan     (isLessThan),
    .overflow       (overflow)
  );

  // Clock and reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model using plain signed arithmetic on 64-bit integers.
  function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [4:0] op, input logic [4:0] sh);
    longint sa;
    longint sb;
    longint wide;
    logic [31:0] r;
    logic ov;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = 32'h0;
    ov = 1'b0;
    case (op)
      5'd0: begin r = a + b; wide = sa + sb; ov = (wide > 64'sd2147483647) || (wide < -64'sd2147483648); end
      5'd1: begin r = a - b; wide = sa - sb; ov = (wide > 64'sd2147483647) || (wide < -64'sd2147483648); end
      5'd2: r = a & b;
      5'd3: r = a | b;
      5'd4: r = a << sh;
      5'd5: r = $signed(a) >>> sh;
`ifdef ALU_EXT_OPS_EN
      5'd6: r = a ^ b;
      5'd7: r = a >> sh;
`endif
      default: r = 32'h0;
    endcase
    return {r, (a != b), (sa < sb), ov};
  endfunction

  // Driver: present one operation, let it pass one edge, then score the outputs.
  task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op,
                       input logic [4:0] sh, input logic rst, input string tag);
    logic [34:0] e;
    @(negedge clock);
    data_operandA  = a;
    data_operandB  = b;
    ctrl_ALUopcode = op;
    ctrl_shiftamt  = sh;
    reset          = rst;
    exp_q.push_back(rst ? 35'h0 : model(a, b, op, sh));
    @(posedge clock);
    #1;
    e = exp_q.pop_front();
    check({tag, ".result"}, data_result, e[34:3]);
    check({tag, ".ne"}, {31'h0, isNotEqual}, {31'h0, e[2]});
    check({tag, ".lt"}, {31'h0, isLessThan}, {31'h0, e[1]});
    check({tag, ".ov"}, {31'h0, overflow}, {31'h0, e[0]});
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h8000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'h0;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  op;
    tests_run      = 0;
    tests_failed   = 0;
    reset          = 1'b1;
    data_operandA  = '0;
    data_operandB  = '0;
    ctrl_ALUopcode = '0;
    ctrl_shiftamt  = '0;

    apply(32'h0, 32'h0, 5'd0, 5'd0, 1'b1, "reset");
    apply(32'h3, 32'h1, 5'd2, 5'd0, 1'b0, "and");
    apply(32'h7FFF_FFFF, 32'h1, 5'd0, 5'd0, 1'b0, "add_ovf");
    apply(32'h8000_0000, 32'h1, 5'd1, 5'd0, 1'b0, "sub_cmp");
    apply(32'h8000_0010, 32'h0, 5'd4, 5'd4, 1'b0, "sll4");
    apply(32'h8000_0010, 32'h0, 5'd5, 5'd4, 1'b0, "sra4");
    apply(32'h8000_0010, 32'h5, 5'd4, 5'd0, 1'b0, "sll0");
    apply(32'h8000_0010, 32'h5, 5'd5, 5'd0, 1'b0, "sra0");
    apply(32'h8000_0000, 32'h0, 5'd5, 5'd31, 1'b0, "sra31");
    apply(32'h1234_5678, 32'h1234_5678, 5'd3, 5'd0, 1'b0, "equal");
    apply(32'h1234_5678, 32'h0F0F_0F0F, 5'd6, 5'd3, 1'b0, "op6");
    apply(32'hF000_0000, 32'h0, 5'd7, 5'd4, 1'b0, "op7");
    apply(32'hDEAD_BEEF, 32'h1, 5'd31, 5'd2, 1'b0, "unused");
    apply(32'd5, 32'd7, 5'd0, 5'd0, 1'b1, "rst_pri");
    apply(32'd5, 32'd7, 5'd0, 5'd0, 1'b0, "post_rst");

    for (int i = 0; i < 300; i++) begin
      a  = pick_operand();
      b  = ($urandom_range(0, 7) == 0) ? a : pick_operand();
      op = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      apply(a, b, op, 5'($urandom_range(0, 31)), 1'b0, "rand");
    end

    if (exp_q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL scoreboard: %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
